// File: rtl/f_fetch_ifid.sv
// ============================================================================
// f_fetch_ifid
// ----------------------------------------------------------------------------
// Fetch stage plus F/D pipeline register of the P5 pipelined MIPS core.
//
// Holds the fetch PC, issues one instruction-memory request at a time over a
// req/gnt/rvalid handshake and captures the returned instruction together with
// its PC+4 into the F/D register. A one-entry buffer keeps a response that
// arrives while decode is stalled, because the memory does not keep rdata
// stable after the rvalid cycle.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset, clears all state
//   npc_in       in   next PC from decode-stage NPC logic, sampled on advance
//   stall        in   hazard-unit stall, holds PC_F and the F/D register
//   imem_req     out  instruction-memory request (registered, high in REQ)
//   imem_addr    out  request address, always PC_F
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   read data valid for the granted request
//   imem_rdata   in   instruction word
//   PC_F         out  current fetch PC
//   PC4_D        out  F/D register: fetched PC + 4
//   instr_D      out  F/D register: instruction word
//   valid_D      out  F/D register holds a real instruction
//   fetch_wait   out  no instruction available this cycle (combinational)
// ============================================================================
module f_fetch_ifid #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_F,
    output logic [31:0] PC4_D,
    output logic [31:0] instr_D,
    output logic        valid_D,
    output logic        fetch_wait
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;
    logic        r_valid;
    logic [31:0] r_buf;

    logic        w_in_wait;
    logic        w_in_hold;
    logic        w_avail;
    logic        w_advance;
    logic [31:0] w_src;
    logic [31:0] w_pc4;

    // An instruction is available either straight off the bus in WAIT or from
    // the buffer in HOLD; rvalid in any other state is a protocol error and is
    // deliberately ignored here.
    assign w_in_wait = (r_state == S_WAIT);
    assign w_in_hold = (r_state == S_HOLD);
    assign w_avail   = (w_in_wait & imem_rvalid) | w_in_hold;
    assign w_advance = w_avail & ~stall;
    assign w_src     = w_in_hold ? r_buf : imem_rdata;
    assign w_pc4     = r_pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_pc    <= RESET_PC;
            r_pc4   <= 32'd0;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_buf   <= 32'd0;
        end else begin
            // F/D register and PC move together, only when decode accepts.
            if (w_advance) begin
                r_pc    <= npc_in;
                r_pc4   <= w_pc4;
                r_instr <= w_src;
                r_valid <= 1'b1;
            end

            case (r_state)
                S_REQ: begin
                    if (imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            // rdata is only valid this cycle; keep a copy.
                            r_buf   <= imem_rdata;
                            r_state <= S_HOLD;
                        end else begin
                            r_buf   <= 32'd0;
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_buf   <= 32'd0;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req   = r_req;
    assign imem_addr  = r_pc;
    assign PC_F       = r_pc;
    assign PC4_D      = r_pc4;
    assign instr_D    = r_instr;
    assign valid_D    = r_valid;
    assign fetch_wait = ~w_avail;

endmodule

// File: doc/f_fetch_ifid.md
# f_fetch_ifid

Fetch stage plus F/D pipeline register for the P5 pipelined MIPS core. Holds the fetch PC (`PC_F`), issues one instruction-memory request at a time over a req/gnt/rvalid handshake, and captures the returned instruction with its `PC+4` into the F/D register. It consumes the decode-stage next-PC value and feeds `PC_F`, `PC4_D` and the decode-stage instruction back to the decode stage. A one-entry response buffer absorbs decode stalls, and `fetch_wait` tells the hazard unit when no instruction is available.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it clears all state immediately.
- `npc_in`  in  32  next PC from the decode-stage NPC logic; sampled only on an advance.
- `stall`  in  1  hazard-unit stall; holds `PC_F` and the F/D register.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  request address; always equals `PC_F`.
- `imem_gnt`  in  1  request accepted in this cycle.
- `imem_rvalid`  in  1  read data valid; asserted only for a previously granted request.
- `imem_rdata`  in  32  instruction word.
- `PC_F`  out  32  current fetch PC.
- `PC4_D`  out  32  F/D register: fetched PC + 4.
- `instr_D`  out  32  F/D register: instruction word.
- `valid_D`  out  1  F/D register holds a real instruction.
- `fetch_wait`  out  1  no instruction available this cycle. The hazard unit must hold D and bubble E while this is high.

## Operation
- The state machine has three states.
  - REQ: `imem_req`=1. On `imem_gnt`, go to WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid`, either advance immediately or buffer (see below).
  - HOLD: the response sits in the buffer; `imem_req`=0.
- Only one request is outstanding at a time. No request is issued in WAIT or HOLD.
- `avail` = (WAIT & `imem_rvalid`) | (HOLD).
- The instruction source is `imem_rdata` in WAIT and the buffer in HOLD.
- `fetch_wait` = !`avail` (combinational).
- `advance` = `avail` & !`stall`. On advance:
  - `PC_F` <= `npc_in`.
  - `instr_D` <= instruction source.
  - `PC4_D` <= `PC_F` + 4 (32-bit add, wraps modulo 2^32).
  - `valid_D` <= 1.
  - State goes to REQ and the buffer is cleared.
- WAIT & `imem_rvalid` & `stall`: the buffer is loaded with `imem_rdata` and the state goes to HOLD. `imem_rdata` is not assumed stable after the rvalid cycle.
- HOLD with `stall` held: stay in HOLD; the buffer is unchanged.
- `stall` while in REQ or WAIT: the request proceeds normally; `PC_F` does not change.
- `PC_F` and the F/D register change only on an advance; otherwise they hold.
- `npc_in` is not checked for alignment; `imem_addr` passes the full 32 bits.
- Branch-delay-slot semantics are preserved. The instruction after a branch is always fetched from the branch's `PC_F`+4 before `npc_in` (the target) is sampled, because the branch stays in D while `fetch_wait` is high.

## Timing
- Reset values:
  - `PC_F`=`RESET_PC`.
  - `PC4_D`=0, `instr_D`=0, `valid_D`=0.
  - State REQ, so `imem_req`=1 with `imem_addr`=`RESET_PC` right after reset release.
  - Buffer empty; `fetch_wait`=1.
- Minimum latency is 2 cycles per instruction. Cycle n: REQ with gnt. Cycle n+1: WAIT with rvalid, advance at the end of n+1. Cycle n+2: REQ for the new PC.
- `imem_gnt` may arrive in the same cycle as `imem_req` or any later cycle; `imem_req` and `imem_addr` stay stable until then.
- `imem_rvalid` arrives no earlier than the cycle after gnt.
- Reset during WAIT or HOLD aborts the fetch; the in-flight response is lost. The instruction memory shares this reset and drops the outstanding read, so no stale `imem_rvalid` follows reset release.
- An `imem_rvalid` seen outside WAIT is a protocol error; it is ignored and does not change state.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release -> `PC_F`=0x3000, `imem_req`=1, `imem_addr`=0x3000, `valid_D`=0, `instr_D`=0, `fetch_wait`=1.
- Zero-wait fetch: gnt in the req cycle, rvalid next cycle with 0x24080001, `npc_in`=0x3004 -> after that edge `instr_D`=0x24080001, `PC4_D`=0x3004, `valid_D`=1, `PC_F`=0x3004; the next request is at 0x3004 one cycle later.
- Slow grant/read: gnt delayed 3 cycles, rvalid 2 cycles after gnt -> `imem_addr` stays at 0x3000 throughout; `fetch_wait`=1 every cycle until the rvalid cycle; exactly one advance.
- Decode stall: `stall`=1 during rvalid (data 0x8C090000), `imem_rdata` changed to garbage the next cycle, `stall` released 4 cycles later -> HOLD for 4 cycles with `instr_D` and `PC_F` unchanged; on release `instr_D`=0x8C090000.
- Branch redirect: PC_F=0x3008 delivered with `npc_in`=0x3100 -> `PC_F`=0x3100, `PC4_D`=0x300C, next `imem_addr`=0x3100.
- Async reset mid-WAIT: assert `reset` between clock edges while in WAIT -> outputs return to reset values immediately, without waiting for an edge; after release the first request is to 0x3000.
